// File: rtl/rf_multiport.sv
// rf_multiport: parametrised multi-read-port register file for the OTTER pipeline.
//
// After reset a clear sequencer walks every register writing zero (DEPTH edges),
// then RF_READY rises and normal operation begins. Register 0 reads as zero and
// ignores writes; addresses >= DEPTH read as zero and ignore writes. Read data is
// registered (one-cycle latency).
//
// Optional feature macro: RF_BYPASS_EN
//   defined   -> write-first: a same-edge write to the read address is returned.
//   undefined -> read-before-write: the old contents are returned.
//
// Parameters:
//   XLEN   data width of each register
//   DEPTH  number of registers (>= 2)
//   NREAD  number of read ports (>= 1)
//
// Ports:
//   CLK       rising-edge clock
//   RST       asynchronous active-high reset
//   RF_ADR    read addresses, port k at [k*AW +: AW]
//   RF_WA     write address
//   RF_WD     write data
//   RF_EN     write enable (ignored while clearing)
//   RF_RS     registered read data, port k at [k*XLEN +: XLEN]
//   RF_READY  high once the clear sequence has completed
module rf_multiport #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NREAD = 2,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREAD*AW-1:0]    RF_ADR,
    input  logic [AW-1:0]          RF_WA,
    input  logic [XLEN-1:0]        RF_WD,
    input  logic                   RF_EN,
    output logic [NREAD*XLEN-1:0]  RF_RS,
    output logic                   RF_READY
);

    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [AW:0]   DepthW  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LastCnt = AW'(DEPTH - 1);

    typedef enum logic {StClear, StRun} state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic [NREAD*XLEN-1:0]   rs_q, rs_d;
    logic [XLEN-1:0]         ram [DEPTH];

    logic                    we;
    logic [AW-1:0]           wa;
    logic [XLEN-1:0]         wd;

    function automatic logic addr_valid(logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < DepthW);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        wa      = RF_WA;
        wd      = RF_WD;
        rs_d    = '0;

        unique case (state_q)
            StClear: begin
                // Sequencer owns the write port; reads stay zero.
                we    = 1'b1;
                wa    = cnt_q;
                wd    = '0;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                we = RF_EN && addr_valid(RF_WA);
                for (int k = 0; k < NREAD; k++) begin
                    if (addr_valid(RF_ADR[k*AW +: AW])) begin
                        rs_d[k*XLEN +: XLEN] = ram[RF_ADR[k*AW +: AW]];
`ifdef RF_BYPASS_EN
                        if (RF_EN && (RF_WA == RF_ADR[k*AW +: AW])) begin
                            rs_d[k*XLEN +: XLEN] = RF_WD;
                        end
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StClear;
            cnt_q   <= '0;
            rs_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
        end
    end

    // Storage has no reset: contents survive RST until the clear sequence rewrites them.
    always_ff @(posedge CLK) begin
        if (we && !RST) begin
            ram[wa] <= wd;
        end
    end

    assign RF_RS    = rs_q;
    assign RF_READY = (state_q == StRun);

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised register file for the OTTER 5-stage pipeline, generalising the 32×32 two-read-port file to configurable data width, depth and read-port count. It adds a post-reset hardware clear sequencer with a ready flag, an optional write-to-read bypass, and range checking for non-power-of-two depths. It sits between decode (read addresses) and writeback (write port). Read data is registered and lands in the decode/execute pipeline register position.

## Interface
- XLEN, default 32: data width of each register.
- DEPTH, default 32: number of registers, must be at least 2. Address width is AW = $clog2(DEPTH).
- NREAD, default 2: number of read ports, must be at least 1.

Ports:
- CLK  in  1: rising-edge clock.
- RST  in  1: reset, asynchronous and active-high.
- RF_ADR  in  NREAD*AW: read addresses; port k uses bits [k*AW +: AW].
- RF_WA  in  AW: write address.
- RF_WD  in  XLEN: write data.
- RF_EN  in  1: write enable.
- RF_RS  out  NREAD*XLEN: registered read data; port k uses bits [k*XLEN +: XLEN].
- RF_READY  out  1: high once the clear sequence has completed.

## Operation
- Storage is DEPTH×XLEN. Register 0 is hardwired to zero:
  - writes to address 0 are discarded;
  - reads of address 0 return 0.
- Out-of-range addresses (≥ DEPTH) read as 0, and writes to them are discarded.
- The state machine has two states, CLEAR and RUN.
  - RST asserted (asynchronous):
    - state goes to CLEAR and the clear counter CNT goes to 0;
    - RF_RS goes to all zeros and RF_READY to 0;
    - storage contents are left unchanged.
  - CLEAR, each rising edge with RST low:
    - write 0 to ram[CNT], then CNT is incremented;
    - when CNT == DEPTH-1 is written, the next state is RUN.
  - While in CLEAR:
    - RF_EN is ignored;
    - every RF_RS port registers 0.
  - RUN:
    - on each edge, if RF_EN, write ram[RF_WA] <= RF_WD, subject to the zero and range rules;
    - each port k registers ram[RF_ADR[k]], subject to the zero and range rules.
  - RUN is left only by RST.
- All read ports are independent. Any number of ports may address the same register in the same cycle.

## Timing
- Read latency is 1 cycle. An address presented before edge N produces data on RF_RS after edge N.
- A write presented before edge N is stored at edge N and is visible to reads sampled at edge N+1 or later.
- A same-cycle read and write of the same non-zero, in-range address depends on RF_BYPASS_EN (see Configuration).
- Clear duration is exactly DEPTH rising edges after RST deasserts.
  - RF_READY rises after the DEPTH-th edge.
  - The first write accepted is on edge DEPTH+1.
- RST asserted mid-clear or mid-operation:
  - immediate return to CLEAR with CNT = 0;
  - outputs go to zero within the same cycle, with no clock needed.
- Reset values:
  - RF_RS = 0;
  - RF_READY = 0;
  - internal state = CLEAR;
  - CNT = 0.

## Configuration
- RF_BYPASS_EN defined (write-first): when RF_EN is high and RF_WA == RF_ADR[k] (non-zero, in range) in RUN, port k registers RF_WD in the same edge.
- RF_BYPASS_EN undefined (read-before-write): port k registers the old contents of the register, and the new value is seen on the following read.

## Test plan
- Reset and clear:
  - stimulus: DEPTH=32, assert RST for 3 cycles, release;
  - required: RF_READY=0 for 32 edges and 1 after edge 32;
  - required: RF_RS=0 throughout;
  - required: RF_EN=1, RF_WA=5, RF_WD=0xFFFF_FFFF during the clear leaves ram[5] reading 0 afterwards.
- Basic write and read:
  - stimulus: write 0xDEADBEEF to register 7;
  - required: the next cycle, port 0 reads 0xDEADBEEF and port 1 reads 0 from register 0 after writing 0x1234 to it.
- Same-cycle collision:
  - stimulus: register 9 holds 0x11; write 0x22 to it while both ports read 9;
  - required with RF_BYPASS_EN: both ports return 0x22;
  - required without RF_BYPASS_EN: 0x11, then 0x22 on the next read.
- Parametrisation:
  - stimulus: XLEN=16, DEPTH=20, NREAD=3; write 0xA5A5 to register 19, then write to 25;
  - required: all 3 ports read 0xA5A5 from 19;
  - required: address 25 reads 0 and ram is unchanged.
- Reset mid-operation:
  - stimulus: RST pulse between clock edges during RUN;
  - required: RF_RS and RF_READY go to 0 before the next edge;
  - required: the clear reruns for DEPTH cycles, and previously written registers then read 0.
